// File: rtl/sram_like_responder_pkg.sv
// Shared types and constants for the SRAM-like responder: size codes, response-queue
// entry layout, timestamp width and stall-LFSR taps.
package sram_like_responder_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } sram_size_e;

   localparam int unsigned TS_W = 8;
   // Full word address width; the memory only decodes the low DEPTH_LOG2 bits.
   localparam int unsigned IDX_W = 30;
   // Taps for x^16 + x^14 + x^13 + x^11 on a left-shifting register.
   localparam logic [15:0] LFSR_POLY = 16'hB400;

   typedef logic [TS_W-1:0] ts_t;

   typedef struct packed {
      logic             wr;
      logic [IDX_W-1:0] idx;
      ts_t              ts;
   } resp_entry_t;

endpackage

// File: rtl/sram_like_responder_if.sv
// SRAM-like request/response bus (req / addr_ok / data_ok) with initiator and
// responder views.
interface sram_like_responder_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wstrb, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wstrb, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_like_responder_resp_fifo.sv
// Synchronous FIFO holding accepted-but-unanswered requests. Depth must be a power of two.
module sram_like_responder_resp_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] din,
   output logic [Width-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [PtrW:0]    wptr_q, wptr_d;
   logic [PtrW:0]    rptr_q, rptr_d;
   logic [Width-1:0] mem_q [Depth];
   logic             do_push, do_pop;

   always_comb begin
      empty   = (wptr_q == rptr_q);
      full    = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      wptr_d  = wptr_q + (PtrW+1)'(do_push);
      rptr_d  = rptr_q + (PtrW+1)'(do_pop);
      dout    = mem_q[rptr_q[PtrW-1:0]];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q[PtrW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like protocol: word memory with in-order responses,
// minimum latency DATA_LAT and optional LFSR-driven stalls.
module sram_like_responder
   import sram_like_responder_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2      = 14,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned DATA_LAT        = 2,
   parameter bit          RAND_EN         = 1'b0,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic               clk,
   input  logic               resetn,
   sram_like_responder_if.slave bus
);

   localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

   logic [CntW-1:0] outst_q, outst_d;
   ts_t             ts_q, ts_d;
   logic [15:0]     lfsr_q, lfsr_d;
   logic            data_ok_q, data_ok_d;
   logic [31:0]     rdata_q, rdata_d;

   logic [31:0]     mem_q [2**DEPTH_LOG2];

   resp_entry_t     push_entry, head;
   logic            fifo_empty, fifo_full;
   logic            full, accept, resp_go;
   ts_t             age;
   logic [DEPTH_LOG2-1:0] widx;

   always_comb begin
      // A response stays in flight until its data_ok cycle ends, so capacity counts it too.
      full       = fifo_full | (outst_q == CntW'(MAX_OUTSTANDING));
      accept     = resetn & bus.req & ~full & (~RAND_EN | lfsr_q[0]);
      widx       = bus.addr[DEPTH_LOG2+1:2];
      push_entry = '{wr: bus.wr, idx: bus.addr[31:2], ts: ts_q};

      // Age as of the coming edge, i.e. the counter value that edge produces.
      age        = ts_q - head.ts + TS_W'(1);
      resp_go    = ~fifo_empty & (age >= TS_W'(DATA_LAT)) & (~RAND_EN | lfsr_q[1]);

      data_ok_d  = resp_go;
      rdata_d    = rdata_q;
      if (resp_go) begin
         rdata_d = head.wr ? 32'h0 : mem_q[head.idx[DEPTH_LOG2-1:0]];
      end

      outst_d    = outst_q + CntW'(accept) - CntW'(data_ok_q);
      ts_d       = ts_q + TS_W'(1);
      lfsr_d     = {lfsr_q[14:0], ^(lfsr_q & LFSR_POLY)};
   end

   assign bus.addr_ok = accept;
   assign bus.data_ok = data_ok_q;
   assign bus.rdata   = rdata_q;

   sram_like_responder_resp_fifo #(
      .Depth (MAX_OUTSTANDING),
      .Width ($bits(resp_entry_t))
   ) u_resp_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (accept),
      .pop    (resp_go),
      .din    (push_entry),
      .dout   (head),
      .empty  (fifo_empty),
      .full   (fifo_full)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         outst_q   <= '0;
         ts_q      <= '0;
         lfsr_q    <= LFSR_SEED;
         data_ok_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         outst_q   <= outst_d;
         ts_q      <= ts_d;
         lfsr_q    <= lfsr_d;
         data_ok_q <= data_ok_d;
         rdata_q   <= rdata_d;
      end
   end

   // Writes land on the handshake edge; a read sampled on that same edge sees old data.
   always_ff @(posedge clk) begin
      if (accept && bus.wr) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.wstrb[i]) begin
               mem_q[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
         end
      end
   end

   logic unused_bits;
   assign unused_bits = ^{bus.size, bus.addr[1:0], head.idx[IDX_W-1:DEPTH_LOG2]};

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed latency/ordering/hazard/reset steps on two
// unstalled instances, then randomized traffic on a stalling instance against a queue model.
module tb_sram_like_responder;
   import sram_like_responder_pkg::*;

   localparam int unsigned LatA   = 2;
   localparam int unsigned LatB   = 4;
   localparam int unsigned MaxOut = 4;
   localparam int          NumTxn = 1016;

   logic        clk    = 1'b0;
   logic        resetn = 1'b0;
   logic        req_a, req_b, req_c, wr;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic [3:0]  wstrb;
   int unsigned n_checks, n_pass;
   int          cyc = 0;

   sram_like_responder_if if_a ();
   sram_like_responder_if if_b ();
   sram_like_responder_if if_c ();

   assign if_a.req = req_a;  assign if_a.wr = wr;  assign if_a.size = size;
   assign if_a.addr = addr;  assign if_a.wstrb = wstrb;  assign if_a.wdata = wdata;
   assign if_b.req = req_b;  assign if_b.wr = wr;  assign if_b.size = size;
   assign if_b.addr = addr;  assign if_b.wstrb = wstrb;  assign if_b.wdata = wdata;
   assign if_c.req = req_c;  assign if_c.wr = wr;  assign if_c.size = size;
   assign if_c.addr = addr;  assign if_c.wstrb = wstrb;  assign if_c.wdata = wdata;

   sram_like_responder #(.DATA_LAT(LatA), .MAX_OUTSTANDING(MaxOut)) dut_a (
      .clk (clk), .resetn (resetn), .bus (if_a)
   );
   sram_like_responder #(.DATA_LAT(LatB), .MAX_OUTSTANDING(MaxOut)) dut_b (
      .clk (clk), .resetn (resetn), .bus (if_b)
   );
   sram_like_responder #(.DATA_LAT(LatA), .MAX_OUTSTANDING(MaxOut), .RAND_EN(1'b1)) dut_c (
      .clk (clk), .resetn (resetn), .bus (if_c)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic aok(input int d);
      case (d)
         0:       return if_a.addr_ok;
         1:       return if_b.addr_ok;
         default: return if_c.addr_ok;
      endcase
   endfunction

   function automatic logic dok(input int d);
      case (d)
         0:       return if_a.data_ok;
         1:       return if_b.data_ok;
         default: return if_c.data_ok;
      endcase
   endfunction

   function automatic logic [31:0] rdat(input int d);
      case (d)
         0:       return if_a.rdata;
         1:       return if_b.rdata;
         default: return if_c.rdata;
      endcase
   endfunction

   task automatic set_req(input int d, input logic v);
      req_a = (d == 0) & v;
      req_b = (d == 1) & v;
      req_c = (d == 2) & v;
   endtask

   task automatic put(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] dat);
      wr = w; addr = a; wstrb = s; wdata = dat;
   endtask

   // One isolated transaction: accepted at once, silent for lat-1 cycles, answered at T+lat.
   task automatic txn(input int d, input int lat, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] dat, input logic [31:0] exp,
                      input string tag);
      put(w, a, s, dat);
      set_req(d, 1'b1);
      #1 chk({tag, "_aok"}, aok(d), 1'b1);
      @(negedge clk);
      set_req(d, 1'b0);
      for (int k = 1; k < lat; k++) begin
         #1 chk({tag, "_early"}, dok(d), 1'b0);
         @(negedge clk);
      end
      #1 chk({tag, "_dok"}, dok(d), 1'b1);
      chk({tag, "_rdata"}, rdat(d), exp);
      @(negedge clk);
   endtask

   typedef struct {
      logic wr;
      int   idx;
      int   acc;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mm [16];

   initial begin
      exp_t        e;
      int          hs, budget, idx, p_idx;
      logic        rq, wr_r, p_v, dk;
      logic [3:0]  s, p_s;
      logic [31:0] p_d;

      n_checks = 0; n_pass = 0;
      set_req(0, 1'b0);
      size = SZ_WORD;
      put(1'b0, 32'h0, 4'h0, 32'h0);

      // Reset state: addr_ok forced low even with req high.
      @(negedge clk);
      set_req(0, 1'b1);
      #1 chk("rst_aok", if_a.addr_ok, 1'b0);
      chk("rst_dok", if_a.data_ok, 1'b0);
      chk("rst_rdata", if_a.rdata, 32'h0);
      @(negedge clk);
      set_req(0, 1'b0);
      resetn = 1'b1;
      @(negedge clk);

      // Single read with aliased upper address bits (word 0x40).
      txn(0, LatA, 1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0, "pre40");
      txn(0, LatA, 1'b0, 32'h1C00_0100, 4'h0, 32'h0, 32'hDEAD_BEEF, "rd40");
      #1 chk("rd40_after", if_a.data_ok, 1'b0);

      // Partial write.
      txn(0, LatA, 1'b1, 32'h0000_0040, 4'hF, 32'hAABB_CCDD, 32'h0, "pre10");
      txn(0, LatA, 1'b1, 32'h0000_0040, 4'b0011, 32'h1234_5678, 32'h0, "pwr");
      txn(0, LatA, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'hAABB_5678, "pwr_rd");

      // Read of word 5 sampled on the same edge that commits a write to word 5.
      txn(0, LatA, 1'b1, 32'h0000_0014, 4'hF, 32'h1111_1111, 32'h0, "pre5");
      put(1'b0, 32'h0000_0014, 4'h0, 32'h0);
      set_req(0, 1'b1);
      #1 chk("hz_rd_aok", if_a.addr_ok, 1'b1);
      @(negedge clk);
      put(1'b1, 32'h0000_0014, 4'hF, 32'h2222_2222);
      #1 chk("hz_wr_aok", if_a.addr_ok, 1'b1);
      chk("hz_early", if_a.data_ok, 1'b0);
      @(negedge clk);
      set_req(0, 1'b0);
      #1 chk("hz_rd_dok", if_a.data_ok, 1'b1);
      chk("hz_old", if_a.rdata, 32'h1111_1111);
      @(negedge clk);
      #1 chk("hz_wr_dok", if_a.data_ok, 1'b1);
      chk("hz_wr_rdata", if_a.rdata, 32'h0);
      @(negedge clk);
      #1 chk("hz_quiet", if_a.data_ok, 1'b0);
      txn(0, LatA, 1'b0, 32'h0000_0014, 4'h0, 32'h0, 32'h2222_2222, "hz_new");

      // Back-to-back reads against a full queue (DATA_LAT=4).
      for (int i = 0; i < 4; i++) begin
         txn(1, LatB, 1'b1, 32'(i * 4), 4'hF, 32'hB0B0_0000 + 32'(i), 32'h0, "b_pre");
      end
      for (int i = 0; i < 4; i++) begin
         put(1'b0, 32'(i * 4), 4'h0, 32'h0);
         set_req(1, 1'b1);
         #1 chk("b2b_aok", if_b.addr_ok, 1'b1);
         chk("b2b_idle", if_b.data_ok, 1'b0);
         @(negedge clk);
      end
      put(1'b0, 32'h0, 4'h0, 32'h0);
      #1 chk("b2b_full", if_b.addr_ok, 1'b0);
      chk("b2b_dok0", if_b.data_ok, 1'b1);
      chk("b2b_rd0", if_b.rdata, 32'hB0B0_0000);
      @(negedge clk);
      #1 chk("b2b_fifth_aok", if_b.addr_ok, 1'b1);
      chk("b2b_dok1", if_b.data_ok, 1'b1);
      chk("b2b_rd1", if_b.rdata, 32'hB0B0_0001);
      @(negedge clk);
      set_req(1, 1'b0);
      for (int i = 2; i < 4; i++) begin
         #1 chk("b2b_dokn", if_b.data_ok, 1'b1);
         chk("b2b_rdn", if_b.rdata, 32'hB0B0_0000 + 32'(i));
         @(negedge clk);
      end
      #1 chk("b2b_gap", if_b.data_ok, 1'b0);
      @(negedge clk);
      #1 chk("b2b_dok5", if_b.data_ok, 1'b1);
      chk("b2b_rd5", if_b.rdata, 32'hB0B0_0000);
      @(negedge clk);

      // Reset with three reads outstanding.
      for (int i = 0; i < 3; i++) begin
         put(1'b0, 32'(i * 4), 4'h0, 32'h0);
         set_req(1, 1'b1);
         #1 chk("mr_aok", if_b.addr_ok, 1'b1);
         @(negedge clk);
      end
      resetn = 1'b0;
      #1 chk("mr_rst_aok", if_b.addr_ok, 1'b0);
      for (int i = 0; i < 2; i++) begin
         chk("mr_rst_dok", if_b.data_ok, 1'b0);
         chk("mr_rst_rdata", if_b.rdata, 32'h0);
         @(negedge clk);
         #1;
      end
      set_req(1, 1'b0);
      resetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1 chk("mr_post_dok", if_b.data_ok, 1'b0);
         @(negedge clk);
      end
      txn(1, LatB, 1'b0, 32'h0000_0008, 4'h0, 32'h0, 32'hB0B0_0002, "mr_new");

      // Randomized traffic with stalls: first 16 handshakes initialise words 0..15.
      hs = 0; budget = 0; p_v = 1'b0; p_idx = 0; p_s = 4'h0; p_d = 32'h0;
      while (budget < 30000 && !(hs >= NumTxn && q.size() == 0)) begin
         if (hs < 16) begin
            rq = 1'b1; wr_r = 1'b1; idx = hs; s = 4'hF;
         end else begin
            rq   = (hs < NumTxn) && ($urandom_range(3) != 0);
            wr_r = 1'($urandom_range(1));
            idx  = int'($urandom_range(15));
            s    = 4'($urandom_range(15));
         end
         addr = {16'($urandom), 10'd0, 4'(idx), 2'($urandom)};
         wdata = $urandom;
         wr = wr_r;
         wstrb = s;
         req_c = rq;
         #1;
         dk = if_c.data_ok;
         if (dk) begin
            chk("r_dok_pending", 32'(q.size() != 0), 32'h1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("r_rdata", if_c.rdata, e.wr ? 32'h0 : mm[e.idx]);
               chk("r_min_lat", 32'((cyc - e.acc) >= int'(LatA)), 32'h1);
            end
         end
         // A write accepted last cycle is invisible to the response seen this cycle.
         if (p_v) begin
            for (int b = 0; b < 4; b++) begin
               if (p_s[b]) mm[p_idx][8*b +: 8] = p_d[8*b +: 8];
            end
            p_v = 1'b0;
         end
         if (q.size() + int'(dk) == int'(MaxOut)) chk("r_cap", if_c.addr_ok, 1'b0);
         chk("r_aok_req", if_c.addr_ok & ~rq, 1'b0);
         if (if_c.addr_ok) begin
            hs++;
            q.push_back('{wr_r, idx, cyc});
            if (wr_r) begin
               p_v = 1'b1; p_idx = idx; p_s = s; p_d = wdata;
            end
         end
         if (q.size() != 0 && (cyc - q[0].acc) > 200) begin
            chk("r_starve", 32'(cyc - q[0].acc), 32'h0);
            budget = 30000;
         end
         @(negedge clk);
         budget++;
      end
      req_c = 1'b0;
      chk("r_all_answered", 32'(hs >= NumTxn && q.size() == 0), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
